// File: rtl/verif_pair_monitor.sv
// Purpose: buffers packed {x, y} words, checks each accepted word against a byte relation, forwards it unchanged.
// Latency: 1 cycle from accept to io_out_bits (no bypass); fail state is registered at the accepting edge.
// Backpressure: io_in_ready = !full & RUN, independent of io_out_ready; HALT blocks intake while the FIFO drains.
//
// Ports:
//   clk, reset (async active-low)
//   io_in_valid/io_in_ready/io_in_bits    upstream word handshake, bits = {x[15:8], y[7:0]}
//   io_mode                               0 none, 1 x==y, 2 x>y unsigned, 3 x+y<256 (sampled on accept)
//   io_halt_on_fail                       first failure enters HALT
//   io_clear                              pulse: clears fail state, leaves HALT (FIFO untouched)
//   io_out_valid/io_out_ready/io_out_bits downstream handshake, FIFO head
//   io_fail, io_fail_cnt, io_last_fail    sticky flag, saturating count, last failing word
//   io_halted                             1 while in HALT
// Optional feature: define VERIF_PAIR_MONITOR_PRINT_EN to print each failing accept in
// simulation (and $finish on it when io_halt_on_fail=1).
module verif_pair_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [15:0]      io_in_bits,
  input  logic [1:0]       io_mode,
  input  logic             io_halt_on_fail,
  input  logic             io_clear,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [15:0]      io_out_bits,
  output logic             io_fail,
  output logic [CNT_W-1:0] io_fail_cnt,
  output logic [15:0]      io_last_fail,
  output logic             io_halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [15:0]      mem_q [DEPTH];
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [15:0]      last_q, last_d;

  logic       full, empty, push, pop, chk_fail, fail_evt;
  logic [7:0] x, y;
  logic [8:0] sum;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign io_in_ready  = !full && (state_q == RUN);
  assign io_out_valid = !empty;
  assign io_out_bits  = mem_q[rd_ptr_q[AW-1:0]];
  assign io_fail      = fail_q;
  assign io_fail_cnt  = cnt_q;
  assign io_last_fail = last_q;
  assign io_halted    = (state_q == HALT);

  assign push = io_in_valid && io_in_ready;
  assign pop  = io_out_valid && io_out_ready;

  assign x   = io_in_bits[15:8];
  assign y   = io_in_bits[7:0];
  assign sum = {1'b0, x} + {1'b0, y};

  always_comb begin
    chk_fail = 1'b0;
    case (io_mode)
      2'd1:    chk_fail = (x != y);
      2'd2:    chk_fail = !(x > y);
      2'd3:    chk_fail = sum[8];
      default: chk_fail = 1'b0;
    endcase
  end

  assign fail_evt = push && chk_fail;

  // A clear applies first, so a coincident failure restarts the count at 1.
  always_comb begin
    cnt_base = io_clear ? '0 : cnt_q;
    fail_d   = io_clear ? 1'b0 : fail_q;
    last_d   = io_clear ? 16'h0000 : last_q;
    cnt_d    = cnt_base;
    if (fail_evt) begin
      fail_d = 1'b1;
      last_d = io_in_bits;
      cnt_d  = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (fail_evt && io_halt_on_fail) state_d = HALT;
      HALT:    if (io_clear) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fail_q   <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= io_in_bits;
  end

`ifdef VERIF_PAIR_MONITOR_PRINT_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && fail_evt) begin
      $display("ASSERTION FAILED: pair %h mode %d", io_in_bits, io_mode);
      if (io_halt_on_fail) $finish;
    end
  end
`endif
`else
  // Print feature disabled: no simulation output, hardware unchanged.
`endif

endmodule
